// File: rtl/alu_wb.sv
// -----------------------------------------------------------------------------
// alu_wb -- ALU write-back stage.
//
// Captures ALU results into a small FIFO and retires them into the register
// file through a single write port. Two-destination operations (128-bit and
// swap-style ops) take two register-file writes: the low result first, then
// the high result. The architectural carry flag updates when an entry retires.
//
// Ports
//   clk, rst_n     : clock (rising edge) and asynchronous active-low reset
//   alu_rdy        : ALU result valid this cycle; pushes one entry
//   alu_result     : low/primary result, written to dst_lo
//   alu_ex_result  : high/secondary result, written to dst_hi when two_dst
//   alu_cout       : carry out, copied to carry_flag on retire when flag_we
//   dst_lo, dst_hi : destination register addresses
//   two_dst        : entry needs both writes
//   flag_we        : entry updates the carry flag
//   rf_ack         : register file accepted the current write
//   rf_we          : register-file write request
//   rf_waddr       : write address (zero when idle)
//   rf_wdata       : write data (zero when idle)
//   carry_flag     : architectural carry flag
//   stall          : buffer full; upstream must not issue
//   wb_done        : one-cycle pulse after an entry fully retires
//   ovf            : sticky; a push was dropped because the buffer was full
// -----------------------------------------------------------------------------
module alu_wb #(
    parameter int LEN_DATA = 64,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                alu_rdy,
    input  logic [LEN_DATA-1:0] alu_result,
    input  logic [LEN_DATA-1:0] alu_ex_result,
    input  logic                alu_cout,
    input  logic [ADDR_W-1:0]   dst_lo,
    input  logic [ADDR_W-1:0]   dst_hi,
    input  logic                two_dst,
    input  logic                flag_we,
    input  logic                rf_ack,
    output logic                rf_we,
    output logic [ADDR_W-1:0]   rf_waddr,
    output logic [LEN_DATA-1:0] rf_wdata,
    output logic                carry_flag,
    output logic                stall,
    output logic                wb_done,
    output logic                ovf
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WR_LO = 2'd1;
    localparam logic [1:0] WR_HI = 2'd2;

    typedef struct packed {
        logic [LEN_DATA-1:0] lo;
        logic [LEN_DATA-1:0] hi;
        logic                cout;
        logic [ADDR_W-1:0]   dst_lo;
        logic [ADDR_W-1:0]   dst_hi;
        logic                two_dst;
        logic                flag_we;
    } entry_t;

    entry_t           entries [DEPTH];
    entry_t           head_e;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [1:0]       state;
    logic [1:0]       next_state;
    logic             push_ok;
    logic             pop;

    assign head_e = entries[head];

    // Stall comes straight from the occupancy register, so upstream never
    // sees a combinational path from this cycle's inputs.
    assign stall = (count == CNT_FULL);

    // A push into a full buffer still succeeds when the head retires on the
    // same edge, because that frees the slot the tail is about to reuse.
    assign push_ok = alu_rdy && (!stall || pop);

    // NOTE: every output of a combinational block gets a default before the
    // case statement; a path that leaves one unassigned would infer a latch.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) next_state = WR_LO;
            end
            WR_LO: begin
                if (rf_ack) begin
                    if (head_e.two_dst) begin
                        next_state = WR_HI;
                    end else begin
                        pop        = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            WR_HI: begin
                if (rf_ack) begin
                    pop        = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The write port is decoded from registered state and the head entry,
    // which cannot change until the pop, so address and data hold steady
    // for as long as the register file withholds rf_ack.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        case (state)
            WR_LO: begin
                rf_we    = 1'b1;
                rf_waddr = head_e.dst_lo;
                rf_wdata = head_e.lo;
            end
            WR_HI: begin
                rf_we    = 1'b1;
                rf_waddr = head_e.dst_hi;
                rf_wdata = head_e.hi;
            end
            default: ;
        endcase
    end

    // NOTE: the entry storage has no reset. Occupancy and pointers are reset,
    // so stale contents are never read, and leaving the array unreset lets it
    // map onto plain flops or RAM without a reset tree.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            entries[tail] <= '{lo:      alu_result,
                               hi:      alu_ex_result,
                               cout:    alu_cout,
                               dst_lo:  dst_lo,
                               dst_hi:  dst_hi,
                               two_dst: two_dst,
                               flag_we: flag_we};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            carry_flag <= 1'b0;
            wb_done    <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state   <= next_state;
            wb_done <= pop;

            if (push_ok) tail <= (tail == PTR_LAST) ? '0 : tail + PTR_W'(1);
            if (pop)     head <= (head == PTR_LAST) ? '0 : head + PTR_W'(1);

            case ({push_ok, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase

            if (pop && head_e.flag_we) carry_flag <= head_e.cout;

            // Dropped push: buffer full and nothing leaving this cycle.
            if (alu_rdy && !push_ok) ovf <= 1'b1;
        end
    end

endmodule

// File: doc/alu_wb.md
ALU_WB -- requirements
Module: alu_wb

Interface
REQ-001 Parameter LEN_DATA, 64, datapath width.
REQ-002 Parameter ADDR_W, 5, register-file address width.
REQ-003 Parameter DEPTH, 2, capture-buffer entries (power of two).
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 alu_rdy  input  1  ALU result valid this cycle (push request).
REQ-007 alu_result  input  LEN_DATA  low/primary ALU result.
REQ-008 alu_ex_result  input  LEN_DATA  high/secondary ALU result.
REQ-009 alu_cout  input  1  ALU carry out.
REQ-010 dst_lo  input  ADDR_W  destination register for alu_result.
REQ-011 dst_hi  input  ADDR_W  destination register for alu_ex_result.
REQ-012 two_dst  input  1  1 = write both results (128-bit/SWR ops).
REQ-013 flag_we  input  1  1 = update carry flag from alu_cout.
REQ-014 rf_ack  input  1  register file accepted current write.
REQ-015 rf_we  output  1  register-file write request.
REQ-016 rf_waddr  output  ADDR_W  write address.
REQ-017 rf_wdata  output  LEN_DATA  write data.
REQ-018 carry_flag  output  1  architectural carry flag (feeds ALU cin[0]).
REQ-019 stall  output  1  buffer full; upstream must not issue.
REQ-020 wb_done  output  1  one-cycle pulse when an entry fully retires.
REQ-021 ovf  output  1  sticky: push dropped while full.

Function
REQ-022 Push: alu_rdy high at rising edge SHALL capture {alu_result, alu_ex_result, alu_cout, dst_lo, dst_hi, two_dst, flag_we} into buffer tail.
REQ-023 Buffer SHALL be FIFO ordered, DEPTH entries, wrap-around pointers with occupancy count 0..DEPTH.
REQ-024 stall SHALL equal (count == DEPTH), registered-state derived, no combinational path from inputs.
REQ-025 Push when full and no pop same cycle: entry dropped, buffer unchanged, ovf set to 1.
REQ-026 Push and pop in same cycle when full: push accepted, count unchanged, ovf unchanged.
REQ-027 FSM states: IDLE, WR_LO, WR_HI.
REQ-028 IDLE: count > 0 -> WR_LO next cycle; else stay.
REQ-029 WR_LO: rf_we=1, rf_waddr=head.dst_lo, rf_wdata=head.alu_result; hold until rf_ack.
REQ-030 WR_LO with rf_ack: head.two_dst=1 -> WR_HI; else pop head, -> IDLE.
REQ-031 WR_HI: rf_we=1, rf_waddr=head.dst_hi, rf_wdata=head.alu_ex_result; with rf_ack pop head, -> IDLE.
REQ-032 rf_we SHALL be 0 in IDLE; rf_waddr/rf_wdata SHALL be 0 in IDLE.
REQ-033 Latency: push at edge N -> rf_we high from cycle N+2 (IDLE->WR_LO transition registered) when buffer was empty.
REQ-034 Pop SHALL set carry_flag <= head.alu_cout if head.flag_we, else carry_flag unchanged.
REQ-035 wb_done SHALL pulse exactly one cycle, the cycle after the pop edge.
REQ-036 rf_ack in IDLE SHALL be ignored.
REQ-037 Outputs rf_waddr/rf_wdata SHALL remain stable while rf_we=1 and rf_ack=0.

Reset
REQ-038 rst_n low SHALL asynchronously force: state IDLE, count 0, pointers 0, rf_we 0, rf_waddr 0, rf_wdata 0, carry_flag 0, stall 0, wb_done 0, ovf 0.
REQ-039 Reset mid-write (WR_LO/WR_HI) SHALL discard all buffered entries; no partial completion after release.
REQ-040 First push accepted at first rising edge with rst_n high.

Verification
REQ-041 Single op: alu_rdy, result=0x5, dst_lo=3, two_dst=0, flag_we=1, cout=1, rf_ack tied 1 -> one write addr 3 data 0x5, carry_flag=1, one wb_done.
REQ-042 Two-dest: result=0xAA, ex_result=0xBB, dst_lo=1, dst_hi=2, two_dst=1 -> writes (1,0xAA) then (2,0xBB), one wb_done after second.
REQ-043 Backpressure: rf_ack=0 for 5 cycles -> rf_we held, addr/data stable; two pushes -> stall=1; third push -> ovf=1, dropped entry never written.
REQ-044 Full with simultaneous push and rf_ack pop -> count stays 2, ovf=0, all three entries written in order.
REQ-045 flag_we=0 with cout=1 after carry_flag=0 -> carry_flag stays 0.
REQ-046 rst_n pulsed low during WR_HI -> all outputs 0 immediately, no further rf_we until new push.
